// File: rtl/fb_scan_if.sv
// Frame-buffer read port shared by fb_scan_reader (master) and the frame buffer (slave).
interface fb_scan_if;
  logic        i_frame_ready;
  logic [11:0] i_read_data;
  logic        o_read_req;
  logic [9:0]  o_read_x;
  logic [8:0]  o_read_y;

  modport master (input i_frame_ready, input i_read_data,
                  output o_read_req, output o_read_x, output o_read_y);
  modport slave  (output i_frame_ready, output i_read_data,
                  input o_read_req, input o_read_x, input o_read_y);
endinterface

// File: rtl/fb_scan_reader.sv
// HDMI-domain frame-buffer scan-out: raster timing, 2:1 upscaled reads, RGB444->RGB888 output.
// Optional macro FB_SCAN_TEST_PATTERN_EN shows colour bars before the first frame is displayed.
module fb_scan_reader #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int SRC_WIDTH    = 320,
  parameter int SRC_HEIGHT   = 240,
  parameter int READ_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  fb_scan_if.master   fb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [23:0] o_rgb,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PD      = READ_LATENCY + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]    X_MAX  = 10'(SRC_WIDTH - 1);
  localparam logic [8:0]    Y_MAX  = 9'(SRC_HEIGHT - 1);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ARMED      = 2'd1,
    DISPLAY    = 2'd2
  } state_t;

  function automatic logic [23:0] rgb444_to_888(input logic [11:0] p);
    return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

  state_t          r_state;
  state_t          w_state_next;
  logic [HW-1:0]   r_h_cnt;
  logic [VW-1:0]   r_v_cnt;
  logic            w_last;
  logic            w_act;
  logic            w_hs;
  logic            w_vs;
  logic            w_first;
  logic            w_req;
  logic [9:0]      w_src_x_raw;
  logic [8:0]      w_src_y_raw;
  logic [9:0]      w_src_x;
  logic [8:0]      w_src_y;
  logic [9:0]      r_read_x;
  logic [8:0]      r_read_y;
  logic [PD:0]     r_act_p;
  logic [PD:0]     r_hs_p;
  logic [PD:0]     r_vs_p;
  logic [PD:0]     r_first_p;
  logic [PD:0]     r_req_p;
  logic [23:0]     w_rgb_next;
  logic [23:0]     r_rgb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= {HW{1'b0}};
      r_v_cnt <= {VW{1'b0}};
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= {HW{1'b0}};
      if (r_v_cnt == V_LAST) r_v_cnt <= {VW{1'b0}};
      else                   r_v_cnt <= r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  always_comb begin
    w_last      = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    w_act       = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    w_hs        = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    w_vs        = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
    w_first     = (r_h_cnt == {HW{1'b0}}) && (r_v_cnt == {VW{1'b0}});
    w_req       = w_act && (r_state == DISPLAY);
    w_src_x_raw = 10'(r_h_cnt >> 1);
    w_src_y_raw = 9'(r_v_cnt >> 1);
    if (w_src_x_raw > X_MAX) w_src_x = X_MAX;
    else                     w_src_x = w_src_x_raw;
    if (w_src_y_raw > Y_MAX) w_src_y = Y_MAX;
    else                     w_src_y = w_src_y_raw;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= WAIT_FRAME;
    else       r_state <= w_state_next;
  end

  // Arming waits for the raster wrap so display always begins at pixel (0,0).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT_FRAME: begin
        if (fb.i_frame_ready) w_state_next = ARMED;
        else                  w_state_next = WAIT_FRAME;
      end
      ARMED: begin
        if (w_last) w_state_next = DISPLAY;
        else        w_state_next = ARMED;
      end
      DISPLAY: w_state_next = DISPLAY;
      default: w_state_next = WAIT_FRAME;
    endcase
  end

  // Index 0 is the request stage; index PD lines up with data returned READ_LATENCY later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act_p   <= {(PD+1){1'b0}};
      r_hs_p    <= {(PD+1){1'b1}};
      r_vs_p    <= {(PD+1){1'b1}};
      r_first_p <= {(PD+1){1'b0}};
      r_req_p   <= {(PD+1){1'b0}};
      r_read_x  <= 10'd0;
      r_read_y  <= 9'd0;
      r_rgb     <= 24'h000000;
    end else begin
      r_act_p   <= {r_act_p[PD-1:0], w_act};
      r_hs_p    <= {r_hs_p[PD-1:0], w_hs};
      r_vs_p    <= {r_vs_p[PD-1:0], w_vs};
      r_first_p <= {r_first_p[PD-1:0], w_first};
      r_req_p   <= {r_req_p[PD-1:0], w_req};
      r_rgb     <= w_rgb_next;
      if (w_req) begin
        r_read_x <= w_src_x;
        r_read_y <= w_src_y;
      end
    end
  end

`ifdef FB_SCAN_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  logic [2:0] w_bar;
  logic [2:0] r_bar_p [PD:0];

  always_comb begin
    w_bar = 3'(int'(r_h_cnt) / BAR_W);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i <= PD; i++) r_bar_p[i] <= 3'd0;
    end else begin
      r_bar_p[0] <= w_bar;
      for (int i = 1; i <= PD; i++) r_bar_p[i] <= r_bar_p[i-1];
    end
  end
`endif

  // A visible pixel without a request can only occur before DISPLAY.
  always_comb begin
    w_rgb_next = 24'h000000;
    if (r_req_p[PD-1]) begin
      w_rgb_next = rgb444_to_888(fb.i_read_data);
    end else if (r_act_p[PD-1]) begin
`ifdef FB_SCAN_TEST_PATTERN_EN
      w_rgb_next = bar_colour(r_bar_p[PD-1]);
`else
      w_rgb_next = 24'h000000;
`endif
    end else begin
      w_rgb_next = 24'h000000;
    end
  end

  assign fb.o_read_req = r_req_p[0];
  assign fb.o_read_x   = r_read_x;
  assign fb.o_read_y   = r_read_y;
  assign o_de          = r_act_p[PD];
  assign o_hsync       = r_hs_p[PD];
  assign o_vsync       = r_vs_p[PD];
  assign o_frame_start = r_first_p[PD];
  assign o_rgb         = r_rgb;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader: full-width lines, vertical timing shortened to 10 lines/frame.
module tb_fb_scan_reader;
  localparam int HA = 640, HFP = 16, HS = 96, HBP = 48, HT = 800;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1, VT = 10;
  localparam int FR = HT * VT;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_hsync, o_vsync, o_de, o_frame_start;
  logic [23:0] o_rgb;

  fb_scan_if fb ();

  fb_scan_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SRC_WIDTH(320), .SRC_HEIGHT(3), .READ_LATENCY(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .fb(fb),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .o_rgb(o_rgb), .o_frame_start(o_frame_start)
  );

  always #5 i_clk = ~i_clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc, mh, mv;
  logic prev_req;
  int   prev_x, prev_y;

  function automatic logic [11:0] pix(input int x, input int y);
    return 12'hABC + 12'(x * 5 + y * 37);
  endfunction

  function automatic logic [23:0] expand(input logic [11:0] p);
    return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

  function automatic int lag_idx(input int k);
    return (mv * HT + mh - k + FR) % FR;
  endfunction

  function automatic logic act_at(input int i);
    return ((i % HT) < HA) && ((i / HT) < VA);
  endfunction

  function automatic logic hs_at(input int i);
    return !(((i % HT) >= HA + HFP) && ((i % HT) < HA + HFP + HS));
  endfunction

  function automatic logic vs_at(input int i);
    return !(((i / HT) >= VA + VFP) && ((i / HT) < VA + VFP + VS));
  endfunction

  // {de, hsync, vsync, frame_start} expected at the output stage this cycle
  function automatic logic [3:0] exp_vid();
    int i;
    if (cyc < 3) return 4'b0110;
    i = lag_idx(3);
    return {act_at(i), hs_at(i), vs_at(i), (i == 0)};
  endfunction

  // Advance one clock; the frame-buffer model answers last cycle's request.
  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    fb.i_read_data = prev_req ? pix(prev_x, prev_y) : 12'h5A5;
    prev_req = fb.o_read_req;
    prev_x   = int'(fb.o_read_x);
    prev_y   = int'(fb.o_read_y);
  endtask

  task automatic release_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    cyc = 0; mh = 0; mv = 0;
    prev_req = 1'b0;
    fb.i_read_data = 12'h5A5;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    fb.i_frame_ready = 1'b0;
    fb.i_read_data = 12'h5A5;
    repeat (3) @(posedge i_clk);
    #1;
    vectors++;
    if ({o_hsync, o_vsync, o_de, o_frame_start} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_sync got %b exp 1100", {o_hsync, o_vsync, o_de, o_frame_start});
    end
    vectors++;
    if ({fb.o_read_req, fb.o_read_x, fb.o_read_y, o_rgb} !== 44'h0) begin
      miscompares++;
      $display("FAIL reset_req got %h exp 0", {fb.o_read_req, fb.o_read_x, fb.o_read_y, o_rgb});
    end
    release_reset();
    tick(); tick();
    vectors++;
    if (o_de !== 1'b0) begin
      miscompares++;
      $display("FAIL de_before_fill got %b exp 0", o_de);
    end
    tick();
    vectors++;
    if ({o_de, o_frame_start} !== 2'b11) begin
      miscompares++;
      $display("FAIL first_pixel got %b exp 11", {o_de, o_frame_start});
    end
    while (mh != 300) tick();
    i_rst = 1'b1;
    #2;
    vectors++;
    if ({o_de, o_hsync, o_vsync, o_frame_start, fb.o_read_req, o_rgb} !== {5'b01100, 24'h0}) begin
      miscompares++;
      $display("FAIL midline_reset got %h exp %h",
               {o_de, o_hsync, o_vsync, o_frame_start, fb.o_read_req, o_rgb}, {5'b01100, 24'h0});
    end
    release_reset();
    tick(); tick(); tick();
    vectors++;
    if ({o_de, o_frame_start} !== 2'b11) begin
      miscompares++;
      $display("FAIL restart_h0 got %b exp 11", {o_de, o_frame_start});
    end
  endtask

  task automatic test_timing();
    bit bad = 1'b0;
    int n_de = 0, n_hs = 0, n_vs = 0, n_fs = 0;
    repeat (2 * FR) begin
      tick();
      if (!bad) begin
        vectors++;
        if ({fb.o_read_req, o_de, o_hsync, o_vsync, o_frame_start, o_rgb} !== {1'b0, exp_vid(), 24'h0}) begin
          miscompares++;
          bad = 1'b1;
          $display("FAIL timing cyc=%0d got %h exp %h", cyc,
                   {fb.o_read_req, o_de, o_hsync, o_vsync, o_frame_start, o_rgb}, {1'b0, exp_vid(), 24'h0});
        end
      end
      n_de += int'(o_de);
      n_hs += int'(!o_hsync);
      n_vs += int'(!o_vsync);
      n_fs += int'(o_frame_start);
    end
    vectors++;
    if (n_de !== 2 * HA * VA) begin
      miscompares++;
      $display("FAIL de_count got %0d exp %0d", n_de, 2 * HA * VA);
    end
    vectors++;
    if (n_hs !== 2 * VT * HS) begin
      miscompares++;
      $display("FAIL hsync_low got %0d exp %0d", n_hs, 2 * VT * HS);
    end
    vectors++;
    if (n_vs !== 2 * VS * HT) begin
      miscompares++;
      $display("FAIL vsync_low got %0d exp %0d", n_vs, 2 * VS * HT);
    end
    vectors++;
    if (n_fs !== 2) begin
      miscompares++;
      $display("FAIL idle_frame_start got %0d exp 2", n_fs);
    end
  endtask

  task automatic test_arming();
    bit found = 1'b0;
    int first = -1;
    i_rst = 1'b1;
    #2;
    release_reset();
    while (!found && cyc < 3 * FR) begin
      tick();
      if (mv == 2 && mh == 0 && cyc < FR) fb.i_frame_ready = 1'b1;
      if (fb.o_read_req === 1'b1) begin
        found = 1'b1;
        first = cyc;
      end
    end
    vectors++;
    if (first !== FR + 1) begin
      miscompares++;
      $display("FAIL first_request cyc got %0d exp %0d", first, FR + 1);
    end
    vectors++;
    if ({fb.o_read_x, fb.o_read_y} !== 19'h0) begin
      miscompares++;
      $display("FAIL first_xy got %0d,%0d exp 0,0", fb.o_read_x, fb.o_read_y);
    end
  endtask

  task automatic test_display();
    bit bad_v = 1'b0, bad_xy = 1'b0, bad_rgb = 1'b0;
    int n_fs = 0, n_src0 = 0, n_srcmax = 0;
    int i1, i3;
    logic [4:0]  ev;
    logic [18:0] exy;
    logic [23:0] ergb;
    while (cyc < 3 * FR + 3) begin
      tick();
      if (mv == 3 && mh == 0 && cyc > 2 * FR) fb.i_frame_ready = 1'b0;
      i1 = lag_idx(1);
      i3 = lag_idx(3);
      ev   = {act_at(i1), exp_vid()};
      exy  = {10'((i1 % HT) / 2), 9'((i1 / HT) / 2)};
      ergb = act_at(i3) ? expand(pix((i3 % HT) / 2, (i3 / HT) / 2)) : 24'h0;
      if (!bad_v) begin
        vectors++;
        if ({fb.o_read_req, o_de, o_hsync, o_vsync, o_frame_start} !== ev) begin
          miscompares++;
          bad_v = 1'b1;
          $display("FAIL display_timing cyc=%0d got %b exp %b", cyc,
                   {fb.o_read_req, o_de, o_hsync, o_vsync, o_frame_start}, ev);
        end
      end
      if (act_at(i1) && !bad_xy) begin
        vectors++;
        if ({fb.o_read_x, fb.o_read_y} !== exy) begin
          miscompares++;
          bad_xy = 1'b1;
          $display("FAIL read_xy cyc=%0d got %0d,%0d exp %0d,%0d", cyc,
                   fb.o_read_x, fb.o_read_y, exy[18:9], exy[8:0]);
        end
      end
      if (!bad_rgb) begin
        vectors++;
        if (o_rgb !== ergb) begin
          miscompares++;
          bad_rgb = 1'b1;
          $display("FAIL rgb cyc=%0d got %h exp %h", cyc, o_rgb, ergb);
        end
      end
      if (i1 == 3 * HT + 5) begin
        vectors++;
        if ({fb.o_read_x, fb.o_read_y} !== {10'd2, 9'd1}) begin
          miscompares++;
          $display("FAIL xy_5_3 got %0d,%0d exp 2,1", fb.o_read_x, fb.o_read_y);
        end
      end
      if (i1 == 5 * HT + 638) begin
        vectors++;
        if ({fb.o_read_x, fb.o_read_y} !== {10'd319, 9'd2}) begin
          miscompares++;
          $display("FAIL xy_max got %0d,%0d exp 319,2", fb.o_read_x, fb.o_read_y);
        end
      end
      if (i3 == 0) begin
        vectors++;
        if ({o_de, o_rgb} !== {1'b1, 24'hAABBCC}) begin
          miscompares++;
          $display("FAIL rgb_abc got %h exp %h", {o_de, o_rgb}, {1'b1, 24'hAABBCC});
        end
      end
      if (cyc > 2 * FR && cyc <= 3 * FR && fb.o_read_req === 1'b1) begin
        if (fb.o_read_x == 10'd0 && fb.o_read_y == 9'd0) n_src0++;
        if (fb.o_read_x == 10'd319 && fb.o_read_y == 9'd2) n_srcmax++;
      end
      n_fs += int'(o_frame_start);
    end
    vectors++;
    if (n_fs !== 3) begin
      miscompares++;
      $display("FAIL frame_start_count got %0d exp 3", n_fs);
    end
    vectors++;
    if ({n_src0, n_srcmax} !== {32'd4, 32'd4}) begin
      miscompares++;
      $display("FAIL replication got %0d,%0d exp 4,4", n_src0, n_srcmax);
    end
  endtask

  task automatic test_reset_in_display();
    while (mh != 300) tick();
    i_rst = 1'b1;
    #2;
    vectors++;
    if ({fb.o_read_req, fb.o_read_x, fb.o_read_y, o_de, o_rgb} !== 44'h0) begin
      miscompares++;
      $display("FAIL display_reset got %h exp 0", {fb.o_read_req, fb.o_read_x, fb.o_read_y, o_de, o_rgb});
    end
  endtask

  task automatic test_ready_at_last();
    bit found = 1'b0;
    int first = -1;
    fb.i_frame_ready = 1'b0;
    release_reset();
    while (cyc < FR - 1) tick();
    fb.i_frame_ready = 1'b1;
    while (!found && cyc < 4 * FR) begin
      tick();
      if (fb.o_read_req === 1'b1) begin
        found = 1'b1;
        first = cyc;
      end
    end
    vectors++;
    if (first !== 2 * FR + 1) begin
      miscompares++;
      $display("FAIL ready_at_last cyc got %0d exp %0d", first, 2 * FR + 1);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_arming();
    test_display();
    test_reset_in_display();
    test_ready_at_last();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
